// File: rtl/pipeline_hazard_controller_if.sv
// rtl/pipeline_hazard_controller_if.sv - hazard controller signal bundle
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_write;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_bubble;
  logic             exmem_stall;
  logic             memwb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // pipeline side: presents hazard sources, consumes buffer controls
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_req, mem_ack,
    input  pc_write, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, memwb_bubble, mem_timeout, stall_cnt, flush_cnt
  );

  // controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd,
           ex_redirect, mem_req, mem_ack,
    output pc_write, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, memwb_bubble, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - 5-stage pipeline stall/flush sequencer
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW_W        = 4,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t            state, state_nxt;
  logic [TW_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              mstall, luse, redirect_taken;

  // hazard detection; a load into x0 never creates a dependency
  always_comb begin
    mstall = (hz.mem_req & ~hz.mem_ack) | (state == ERR);
    luse   = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
             ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
              (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
  end

  // state and wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // memory wait sequencing; ERR holds until reset and ignores late acks
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (hz.mem_req && !hz.mem_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = TW_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.mem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TW_W'(MEM_TIMEOUT)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + TW_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  // prioritised buffer controls: memory stall, redirect, load-use, normal flow
  always_comb begin
    hz.pc_write     = 1'b1;
    hz.ifid_stall   = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.idex_stall   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.exmem_stall  = 1'b0;
    hz.memwb_bubble = 1'b0;
    redirect_taken  = 1'b0;
    if (mstall) begin
      hz.pc_write     = 1'b0;
      hz.ifid_stall   = 1'b1;
      hz.idex_stall   = 1'b1;
      hz.exmem_stall  = 1'b1;
      hz.memwb_bubble = 1'b1;
    end else if (hz.ex_redirect) begin
      hz.ifid_flush   = 1'b1;
      hz.idex_bubble  = 1'b1;
      redirect_taken  = 1'b1;
    end else if (luse) begin
      hz.pc_write     = 1'b0;
      hz.ifid_stall   = 1'b1;
      hz.idex_bubble  = 1'b1;
    end
  end

  // saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!hz.pc_write && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_taken && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;
  assign hz.mem_timeout = (state == ERR);

endmodule
